clock_mode_ctrl: RTL and testbench

//  Fully synchronous mode/setup controller for the HMS digital clock. It debounces the three

---
 rtl/clock_mode_ctrl_pkg.sv | 53 +++++
 rtl/clock_mode_ctrl_if.sv | 28 ++
 rtl/clock_mode_ctrl_btn_debounce.sv | 40 ++++
 rtl/clock_mode_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_mode_ctrl_pkg.sv
// Shared encodings for the HMS clock mode/setup path: mode and position codes,
// blink-mask pair positions and the controller debug view.
package clock_mode_ctrl_pkg;

  typedef enum logic {
    MODE_CLOCK = 1'b0,
    MODE_SETUP = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_t;

  localparam int MASK_SEC_LSB  = 0;
  localparam int MASK_MIN_LSB  = 2;
  localparam int MASK_HOUR_LSB = 4;

  localparam int BTN_MODE = 0;
  localparam int BTN_POS  = 1;
  localparam int BTN_INC  = 2;

  typedef struct packed {
    mode_t      state;
    logic [2:0] btn_level;
  } dbg_t;

  function automatic int cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic pos_t next_pos(pos_t p);
    case (p)
      POS_SEC: return POS_MIN;
      POS_MIN: return POS_HOUR;
      default: return POS_SEC;
    endcase
  endfunction

  function automatic logic [5:0] pair_mask(pos_t p, logic on);
    logic [5:0] m;
    m = '0;
    case (p)
      POS_SEC:  m[MASK_SEC_LSB  +: 2] = {2{on}};
      POS_MIN:  m[MASK_MIN_LSB  +: 2] = {2{on}};
      POS_HOUR: m[MASK_HOUR_LSB +: 2] = {2{on}};
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// Counter/display side of the mode controller: carry levels in, increment
// enables, mode, position, blink mask and a debug view out.
interface clock_mode_ctrl_if;
  import clock_mode_ctrl_pkg::*;

  // o_*_inc are single-cycle enables with no back-pressure: the counters must
  // act on every cycle one is high; i_*_max are levels sampled on tick cycles.
  logic       i_sec_max;
  logic       i_min_max;
  logic       o_mode;
  logic [1:0] o_position;
  logic       o_sec_inc;
  logic       o_min_inc;
  logic       o_hour_inc;
  logic [5:0] o_blink_mask;
  dbg_t       dbg;

  modport master (
    input  i_sec_max, i_min_max,
    output o_mode, o_position, o_sec_inc, o_min_inc, o_hour_inc, o_blink_mask, dbg
  );

  modport slave (
    output i_sec_max, i_min_max,
    input  o_mode, o_position, o_sec_inc, o_min_inc, o_hour_inc, o_blink_mask, dbg
  );

endinterface

// File: rtl/clock_mode_ctrl_btn_debounce.sv
// One push-button: 2-FF synchronizer, strobe-sampled two-sample filter and a
// single-cycle press pulse on the released->pressed transition.
module clock_mode_ctrl_btn_debounce (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_stb,
  input  logic sw_n,
  output logic level,
  output logic press
);

  logic [1:0] sync_q;
  logic       samp_q;
  logic       armed_q;

  // Sync/sample start as "pressed" so the filter only arms after two genuine
  // released samples: a button held through reset never produces a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      samp_q  <= 1'b1;
      armed_q <= 1'b0;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], ~sw_n};
      press  <= 1'b0;
      if (sample_stb) begin
        samp_q <= sync_q[1];
        if (!armed_q) begin
          armed_q <= ~sync_q[1] & ~samp_q;
        end else if (sync_q[1] == samp_q) begin
          level <= samp_q;
          press <= samp_q & ~level;
        end
      end
    end
  end

endmodule

// File: rtl/clock_mode_ctrl.sv
// HMS clock mode/setup controller: button debounce, CLOCK/SETUP FSM, 1 Hz tick
// with sec->min->hour carry, setup increment with auto-repeat, and blink mask.
module clock_mode_ctrl
  import clock_mode_ctrl_pkg::*;
#(
  parameter int unsigned SEC_DIV    = 50_000_000,
  parameter int unsigned DEB_CYC    = 500_000,
  parameter int unsigned REPEAT_DLY = 25_000_000,
  parameter int unsigned REPEAT_PER = 12_500_000,
  parameter int unsigned BLINK_DIV  = 12_500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sw_mode,
  input  logic              i_sw_pos,
  input  logic              i_sw_inc,
  clock_mode_ctrl_if.master bus
);

  localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int PW = cnt_width(SEC_DIV);
  localparam int DW = cnt_width(DEB_CYC);
  localparam int RW = cnt_width(REP_MAX);
  localparam int BW = cnt_width(BLINK_DIV);

  localparam logic [PW-1:0] SEC_TC   = PW'(SEC_DIV - 1);
  localparam logic [DW-1:0] DEB_TC   = DW'(DEB_CYC - 1);
  localparam logic [RW-1:0] DLY_TC   = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] PER_TC   = RW'(REPEAT_PER - 1);
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);

  // Shared debounce sample strobe
  logic [DW-1:0] deb_cnt_q;
  logic          deb_stb;
  assign deb_stb = (deb_cnt_q == DEB_TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) deb_cnt_q <= '0;
    else        deb_cnt_q <= deb_stb ? '0 : deb_cnt_q + 1'b1;
  end

  logic [2:0] btn_level;
  logic [2:0] btn_press;
  logic [2:0] sw_n;
  assign sw_n = {i_sw_inc, i_sw_pos, i_sw_mode};

  for (genvar g = 0; g < 3; g++) begin : g_btn
    clock_mode_ctrl_btn_debounce u_deb (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_stb (deb_stb),
      .sw_n       (sw_n[g]),
      .level      (btn_level[g]),
      .press      (btn_press[g])
    );
  end

  mode_t         state_q, state_d;
  pos_t          pos_q, pos_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_act_q, rep_act_d;
  logic          rep_first_q, rep_first_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          toggle_q, toggle_d;
  logic          sec_inc_q, sec_inc_d;
  logic          min_inc_q, min_inc_d;
  logic          hour_inc_q, hour_inc_d;
  logic [5:0]    mask_q, mask_d;
  logic          edit_pulse;
  logic          restart_blink;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MODE_CLOCK;
      pos_q       <= POS_SEC;
      presc_q     <= '0;
      rep_cnt_q   <= '0;
      rep_act_q   <= 1'b0;
      rep_first_q <= 1'b0;
      blink_cnt_q <= '0;
      toggle_q    <= 1'b0;
      sec_inc_q   <= 1'b0;
      min_inc_q   <= 1'b0;
      hour_inc_q  <= 1'b0;
      mask_q      <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      presc_q     <= presc_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_act_q   <= rep_act_d;
      rep_first_q <= rep_first_d;
      blink_cnt_q <= blink_cnt_d;
      toggle_q    <= toggle_d;
      sec_inc_q   <= sec_inc_d;
      min_inc_q   <= min_inc_d;
      hour_inc_q  <= hour_inc_d;
      mask_q      <= mask_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pos_d         = pos_q;
    presc_d       = presc_q;
    rep_cnt_d     = rep_cnt_q;
    rep_act_d     = rep_act_q;
    rep_first_d   = rep_first_q;
    blink_cnt_d   = blink_cnt_q;
    toggle_d      = toggle_q;
    sec_inc_d     = 1'b0;
    min_inc_d     = 1'b0;
    hour_inc_d    = 1'b0;
    edit_pulse    = 1'b0;
    restart_blink = 1'b0;

    // Priority mode > pos > inc: a lower-priority press in the same cycle is dropped
    if (btn_press[BTN_MODE]) begin
      state_d       = (state_q == MODE_CLOCK) ? MODE_SETUP : MODE_CLOCK;
      pos_d         = POS_SEC;
      rep_act_d     = 1'b0;
      restart_blink = 1'b1;
    end else if (state_q == MODE_SETUP) begin
      if (btn_press[BTN_POS]) begin
        pos_d         = next_pos(pos_q);
        rep_act_d     = 1'b0;
        restart_blink = 1'b1;
      end else if (btn_press[BTN_INC]) begin
        edit_pulse  = 1'b1;
        rep_act_d   = 1'b1;
        rep_first_d = 1'b1;
        rep_cnt_d   = '0;
      end else if (rep_act_q) begin
        if (!btn_level[BTN_INC]) begin
          rep_act_d = 1'b0;
        end else if (rep_cnt_q == (rep_first_q ? DLY_TC : PER_TC)) begin
          edit_pulse  = 1'b1;
          rep_cnt_d   = '0;
          rep_first_d = 1'b0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
    end

    if (edit_pulse) begin
      restart_blink = 1'b1;
      case (pos_q)
        POS_SEC:  sec_inc_d  = 1'b1;
        POS_MIN:  min_inc_d  = 1'b1;
        POS_HOUR: hour_inc_d = 1'b1;
        default:  sec_inc_d  = 1'b0;
      endcase
    end

    // Prescaler only runs across CLOCK->CLOCK cycles, so it restarts at 0 on exit
    if (state_q == MODE_CLOCK && state_d == MODE_CLOCK) begin
      if (presc_q == SEC_TC) begin
        presc_d    = '0;
        sec_inc_d  = 1'b1;
        min_inc_d  = bus.i_sec_max;
        hour_inc_d = bus.i_sec_max & bus.i_min_max;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else begin
      presc_d = '0;
    end

    if (state_d != MODE_SETUP || restart_blink) begin
      blink_cnt_d = '0;
      toggle_d    = 1'b0;
    end else if (blink_cnt_q == BLINK_TC) begin
      blink_cnt_d = '0;
      toggle_d    = ~toggle_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end

    mask_d = (state_d == MODE_SETUP) ? pair_mask(pos_d, toggle_d) : 6'b0;
  end

  assign bus.o_mode        = (state_q == MODE_SETUP);
  assign bus.o_position    = pos_q;
  assign bus.o_sec_inc     = sec_inc_q;
  assign bus.o_min_inc     = min_inc_q;
  assign bus.o_hour_inc    = hour_inc_q;
  assign bus.o_blink_mask  = mask_q;
  assign bus.dbg.state     = state_q;
  assign bus.dbg.btn_level = btn_level;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with small timing parameters.
module tb_clock_mode_ctrl;
  import clock_mode_ctrl_pkg::*;

  localparam int SEC_DIV    = 10;
  localparam int DEB_CYC    = 2;
  localparam int REPEAT_DLY = 20;
  localparam int REPEAT_PER = 5;
  localparam int BLINK_DIV  = 8;
  localparam int B_MODE = 0;
  localparam int B_POS  = 1;
  localparam int B_INC  = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sw_n  = 3'b111;

  clock_mode_ctrl_if bus ();

  clock_mode_ctrl #(
    .SEC_DIV    (SEC_DIV),
    .DEB_CYC    (DEB_CYC),
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER),
    .BLINK_DIV  (BLINK_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_sw_mode (sw_n[B_MODE]),
    .i_sw_pos  (sw_n[B_POS]),
    .i_sw_inc  (sw_n[B_INC]),
    .bus       (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int sec_n  = 0;
  int min_n  = 0;
  int hour_n = 0;
  int min_times[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.o_sec_inc) sec_n++;
    if (bus.o_min_inc) begin
      min_n++;
      min_times.push_back(cyc);
    end
    if (bus.o_hour_inc) hour_n++;
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(input int b);
    sw_n[b] = 1'b0;
    step(8);
    sw_n[b] = 1'b1;
    step(10);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    sw_n  = 3'b111;
    bus.i_sec_max = 1'b0;
    bus.i_min_max = 1'b0;
    step(3);
    checks++;
    if ({bus.o_mode, bus.o_position} !== 3'b000) begin
      errors++; $display("FAIL reset_mode_pos: got %0b/%0d expected 0/0", bus.o_mode, bus.o_position);
    end
    checks++;
    if ({bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc, bus.o_blink_mask} !== 9'd0) begin
      errors++; $display("FAIL reset_outputs: inc=%b%b%b mask=%b expected all 0",
                         bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc, bus.o_blink_mask);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      step(1);
      checks++;
      if (bus.o_sec_inc !== logic'(k % 10 == 0)) begin
        errors++; $display("FAIL idle_sec_tick cycle %0d: got %b expected %b", k, bus.o_sec_inc, (k % 10 == 0));
      end
      checks++;
      if ({bus.o_min_inc, bus.o_hour_inc, bus.o_mode, bus.o_blink_mask} !== 9'd0) begin
        errors++; $display("FAIL idle_other cycle %0d: min=%b hour=%b mode=%b mask=%b expected 0",
                           k, bus.o_min_inc, bus.o_hour_inc, bus.o_mode, bus.o_blink_mask);
      end
    end
  endtask

  task automatic test_carry;
    bit found = 0;
    bus.i_sec_max = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (bus.o_sec_inc) begin found = 1; break; end
      checks++;
      if (bus.o_min_inc !== 1'b0) begin
        errors++; $display("FAIL carry_no_tick: min_inc=%b expected 0", bus.o_min_inc);
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL carry_tick_timeout: no sec_inc within 12 cycles"); end
    checks++;
    if ({bus.o_min_inc, bus.o_hour_inc} !== 2'b10) begin
      errors++; $display("FAIL carry_min: min/hour=%b%b expected 10", bus.o_min_inc, bus.o_hour_inc);
    end
    bus.i_min_max = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      checks++;
      if (bus.o_sec_inc !== logic'(k == 10)) begin
        errors++; $display("FAIL carry_period offset %0d: sec_inc=%b expected %b", k, bus.o_sec_inc, (k == 10));
      end
    end
    checks++;
    if ({bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc} !== 3'b111) begin
      errors++; $display("FAIL carry_hour: inc=%b%b%b expected 111", bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc);
    end
    bus.i_sec_max = 1'b0;
    bus.i_min_max = 1'b0;
  endtask

  task automatic test_setup_entry;
    bit found = 0;
    int s0;
    sw_n[B_MODE] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.o_mode) begin found = 1; break; end
    end
    sw_n[B_MODE] = 1'b1;
    bus.i_sec_max = 1'b1;
    bus.i_min_max = 1'b1;
    s0 = sec_n + min_n + hour_n;
    checks++;
    if (!found) begin errors++; $display("FAIL setup_enter_timeout: mode still %b", bus.o_mode); end
    checks++;
    if (bus.o_position !== 2'd0 || bus.dbg.state !== MODE_SETUP) begin
      errors++; $display("FAIL setup_enter_state: pos=%0d state=%0d expected 0/1", bus.o_position, bus.dbg.state);
    end
    for (int k = 0; k < 50; k++) begin
      if (k > 0) step(1);
      checks++;
      if (bus.o_blink_mask !== (((k / 8) % 2 == 1) ? 6'b000011 : 6'b000000)) begin
        errors++; $display("FAIL setup_blink offset %0d: mask=%b expected %b", k, bus.o_blink_mask,
                           (((k / 8) % 2 == 1) ? 6'b000011 : 6'b000000));
      end
    end
    checks++;
    if (sec_n + min_n + hour_n != s0 || bus.o_mode !== 1'b1) begin
      errors++; $display("FAIL setup_no_inc: inc pulses %0d expected %0d, mode=%b", sec_n + min_n + hour_n, s0, bus.o_mode);
    end
    bus.i_sec_max = 1'b0;
    bus.i_min_max = 1'b0;
  endtask

  task automatic test_position;
    bit found = 0;
    int s0, m0, h0;
    tap(B_POS);
    checks++;
    if (bus.o_position !== 2'd1) begin errors++; $display("FAIL pos_step1: got %0d expected 1", bus.o_position); end
    sw_n[B_POS] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.o_position == 2'd2) begin found = 1; break; end
    end
    sw_n[B_POS] = 1'b1;
    checks++;
    if (!found) begin errors++; $display("FAIL pos_step2_timeout: pos=%0d expected 2", bus.o_position); end
    checks++;
    if (bus.o_blink_mask !== 6'b000000) begin errors++; $display("FAIL pos_blink_restart: mask=%b expected 000000", bus.o_blink_mask); end
    step(7);
    checks++;
    if (bus.o_blink_mask !== 6'b000000) begin errors++; $display("FAIL pos_blink_7: mask=%b expected 000000", bus.o_blink_mask); end
    step(1);
    checks++;
    if (bus.o_blink_mask !== 6'b110000) begin errors++; $display("FAIL pos_blink_8: mask=%b expected 110000", bus.o_blink_mask); end
    step(4);
    s0 = sec_n; m0 = min_n; h0 = hour_n;
    tap(B_INC);
    checks++;
    if (hour_n != h0 + 1 || sec_n != s0 || min_n != m0) begin
      errors++; $display("FAIL inc_tap_hour: sec/min/hour pulses %0d/%0d/%0d expected 0/0/1", sec_n - s0, min_n - m0, hour_n - h0);
    end
    tap(B_POS);
    checks++;
    if (bus.o_position !== 2'd0 || bus.o_blink_mask[5:4] !== 2'b00) begin
      errors++; $display("FAIL pos_wrap: pos=%0d mask[5:4]=%b expected 0/00", bus.o_position, bus.o_blink_mask[5:4]);
    end
  endtask

  task automatic test_repeat;
    int s0, h0, t0, rel, n;
    tap(B_POS);
    checks++;
    if (bus.o_position !== 2'd1) begin errors++; $display("FAIL repeat_pos: got %0d expected 1", bus.o_position); end
    min_times.delete();
    exp_q.delete();
    s0 = sec_n; h0 = hour_n; t0 = cyc;
    sw_n[B_INC] = 1'b0;
    step(60);
    rel = cyc;
    sw_n[B_INC] = 1'b1;
    step(40);
    n = min_times.size();
    checks++;
    if (n < 8) begin errors++; $display("FAIL repeat_count: got %0d pulses expected at least 8", n); end
    if (n > 0) begin
      checks++;
      if (min_times[0] - t0 < 1 || min_times[0] - t0 > 10) begin
        errors++; $display("FAIL repeat_first: pulse %0d cycles after press expected 1..10", min_times[0] - t0);
      end
      checks++;
      if (min_times[n-1] > rel + 8 || min_times[n-1] < rel - 5) begin
        errors++; $display("FAIL repeat_stop: last pulse at %0d, release at %0d, expected within -5..+8", min_times[n-1], rel);
      end
    end
    exp_q.push_back(8'(REPEAT_DLY));
    for (int i = 2; i < n; i++) exp_q.push_back(8'(REPEAT_PER));
    for (int i = 1; i < n; i++) begin
      logic [7:0] exp_gap;
      exp_gap = exp_q.pop_front();
      checks++;
      if (8'(min_times[i] - min_times[i-1]) !== exp_gap) begin
        errors++; $display("FAIL repeat_gap %0d: got %0d expected %0d", i, min_times[i] - min_times[i-1], exp_gap);
      end
    end
    checks++;
    if (sec_n != s0 || hour_n != h0) begin
      errors++; $display("FAIL repeat_other: sec/hour pulses %0d/%0d expected 0/0", sec_n - s0, hour_n - h0);
    end
  endtask

  task automatic test_mode_inc;
    bit found = 0;
    int s0, m0, h0;
    m0 = min_n; h0 = hour_n;
    sw_n[B_MODE] = 1'b0;
    sw_n[B_INC]  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (!bus.o_mode) begin found = 1; break; end
    end
    sw_n[B_MODE] = 1'b1;
    sw_n[B_INC]  = 1'b1;
    checks++;
    if (!found) begin errors++; $display("FAIL exit_timeout: mode still %b", bus.o_mode); end
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) step(1);
      checks++;
      if (bus.o_sec_inc !== logic'(k == 10)) begin
        errors++; $display("FAIL exit_first_tick offset %0d: sec_inc=%b expected %b", k, bus.o_sec_inc, (k == 10));
      end
    end
    step(10);
    checks++;
    if (min_n != m0 || hour_n != h0) begin
      errors++; $display("FAIL mode_inc_exit: min/hour pulses %0d/%0d expected 0/0", min_n - m0, hour_n - h0);
    end
    found = 0;
    sw_n[B_MODE] = 1'b0;
    sw_n[B_INC]  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.o_mode) begin found = 1; break; end
    end
    s0 = sec_n; m0 = min_n; h0 = hour_n;
    step(20);
    sw_n[B_MODE] = 1'b1;
    sw_n[B_INC]  = 1'b1;
    step(15);
    checks++;
    if (!found) begin errors++; $display("FAIL enter_timeout: mode still %b", bus.o_mode); end
    checks++;
    if (sec_n != s0 || min_n != m0 || hour_n != h0) begin
      errors++; $display("FAIL mode_inc_enter: pulses %0d/%0d/%0d expected 0/0/0", sec_n - s0, min_n - m0, hour_n - h0);
    end
  endtask

  task automatic test_reset_mid;
    int s0, m0, h0;
    tap(B_POS);
    sw_n[B_INC] = 1'b0;
    step(30);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_mode, bus.o_position} !== 3'b000 || bus.dbg.state !== MODE_CLOCK) begin
      errors++; $display("FAIL midreset_mode: mode=%b pos=%0d expected 0/0", bus.o_mode, bus.o_position);
    end
    checks++;
    if ({bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc, bus.o_blink_mask} !== 9'd0) begin
      errors++; $display("FAIL midreset_outputs: inc=%b%b%b mask=%b expected all 0",
                         bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc, bus.o_blink_mask);
    end
    step(1);
    rst_n = 1'b1;
    step(12);
    tap(B_MODE);
    checks++;
    if (bus.o_mode !== 1'b1 || bus.o_position !== 2'd0) begin
      errors++; $display("FAIL midreset_setup: mode=%b pos=%0d expected 1/0", bus.o_mode, bus.o_position);
    end
    s0 = sec_n; m0 = min_n; h0 = hour_n;
    step(30);
    checks++;
    if (sec_n != s0 || min_n != m0 || hour_n != h0) begin
      errors++; $display("FAIL held_through_reset: pulses %0d/%0d/%0d expected 0/0/0", sec_n - s0, min_n - m0, hour_n - h0);
    end
    sw_n[B_INC] = 1'b1;
    step(12);
    tap(B_INC);
    checks++;
    if (sec_n != s0 + 1 || min_n != m0 || hour_n != h0) begin
      errors++; $display("FAIL retap_after_reset: pulses %0d/%0d/%0d expected 1/0/0", sec_n - s0, min_n - m0, hour_n - h0);
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_setup_entry();
    test_position();
    test_repeat();
    test_mode_inc();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
